bp_update_scheduler: RTL and testbench

//  Sequences all writes into the branch-predictor tables (GBP/LBP counters, BTB) through one shared write port.

---
 rtl/bp_update_scheduler.sv | 161 ++++++++++++++++
 tb/tb_bp_update_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_scheduler.sv
// Single write-port scheduler for the branch-predictor tables: clears every index after reset
// or flush, then drains resolved-branch updates from a small FIFO one per unstalled cycle.
module bp_update_scheduler #(
    parameter int unsigned IDX_W = 10,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                STALL,
    input  logic                flush_req,
    input  logic                upd_valid,
    input  logic [31:0]         upd_pc,
    input  logic                upd_taken,
    input  logic [31:0]         upd_target,
    output logic                upd_ready,
    output logic                tbl_we,
    output logic                tbl_clear,
    output logic [IDX_W-1:0]    tbl_idx,
    output logic [29-IDX_W:0]   tbl_tag,
    output logic                tbl_taken,
    output logic [31:0]         tbl_target,
    output logic                init_done,
    output logic [CNT_W-1:0]    drop_cnt
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    typedef struct packed {
        logic [29:0] pc_hi;
        logic        taken;
        logic [31:0] target;
    } entry_t;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   sweep_q, sweep_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d, count;
    logic [CNT_W-1:0]   drop_q, drop_d;
    entry_t             mem_q [DEPTH];
    entry_t             new_entry, head;
    logic               push;

    logic               we_q, we_d, clear_q, clear_d, taken_q, taken_d;
    logic               init_done_q, init_done_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [29-IDX_W:0]  tag_q, tag_d;
    logic [31:0]        target_q, target_d;

    // Byte-offset bits of the PC never reach the tables.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^upd_pc[1:0];

    assign count     = wptr_q - rptr_q;
    assign upd_ready = (state_q == StRun) && (count < PTR_W'(DEPTH)) && !flush_req;
    assign push      = upd_valid && upd_ready;
    assign new_entry = {upd_pc[31:2], upd_taken, upd_target};
    assign head      = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        drop_d      = drop_q;
        we_d        = 1'b0;
        clear_d     = 1'b0;
        idx_d       = '0;
        tag_d       = '0;
        taken_d     = 1'b0;
        target_d    = '0;
        init_done_d = 1'b0;

        if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (upd_valid && !upd_ready && (drop_q != '1)) begin
            drop_d = drop_q + CNT_W'(1);
        end

        if (flush_req) begin
            state_d = StInit;
            sweep_d = '0;
            wptr_d  = '0;
            rptr_d  = '0;
        end else begin
            unique case (state_q)
                StInit: begin
                    we_d    = 1'b1;
                    clear_d = 1'b1;
                    idx_d   = sweep_q;
                    sweep_d = sweep_q + IDX_W'(1);
                    if (sweep_q == '1) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    init_done_d = 1'b1;
                    // STALL freezes the drain only; enqueue continues above.
                    if ((count != '0) && !STALL) begin
                        rptr_d   = rptr_q + PTR_W'(1);
                        we_d     = 1'b1;
                        idx_d    = head.pc_hi[IDX_W-1:0];
                        tag_d    = head.pc_hi[29:IDX_W];
                        taken_d  = head.taken;
                        target_d = head.target;
                    end
                end
                default: state_d = StInit;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= StInit;
            sweep_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            drop_q      <= '0;
            we_q        <= 1'b0;
            clear_q     <= 1'b0;
            idx_q       <= '0;
            tag_q       <= '0;
            taken_q     <= 1'b0;
            target_q    <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            drop_q      <= drop_d;
            we_q        <= we_d;
            clear_q     <= clear_d;
            idx_q       <= idx_d;
            tag_q       <= tag_d;
            taken_q     <= taken_d;
            target_q    <= target_d;
            init_done_q <= init_done_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= new_entry;
        end
    end

    assign tbl_we     = we_q;
    assign tbl_clear  = clear_q;
    assign tbl_idx    = idx_q;
    assign tbl_tag    = tag_q;
    assign tbl_taken  = taken_q;
    assign tbl_target = target_q;
    assign init_done  = init_done_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Scoreboard bench for bp_update_scheduler (IDX_W=3, DEPTH=4, CNT_W=4): stimulus queues expected
// table writes, a negedge monitor pops and compares every tbl_we cycle.
module tb_bp_update_scheduler;

    localparam int unsigned IDX_W = 3;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 4;
    localparam int          DROP_MAX = 15;

    logic                CLK = 1'b0;
    logic                RESET = 1'b0;
    logic                STALL = 1'b0;
    logic                flush_req = 1'b0;
    logic                upd_valid = 1'b0;
    logic [31:0]         upd_pc = '0;
    logic                upd_taken = 1'b0;
    logic [31:0]         upd_target = '0;
    logic                upd_ready;
    logic                tbl_we;
    logic                tbl_clear;
    logic [IDX_W-1:0]    tbl_idx;
    logic [29-IDX_W:0]   tbl_tag;
    logic                tbl_taken;
    logic [31:0]         tbl_target;
    logic                init_done;
    logic [CNT_W-1:0]    drop_cnt;

    bp_update_scheduler #(.IDX_W(IDX_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .STALL      (STALL),
        .flush_req  (flush_req),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target),
        .upd_ready  (upd_ready),
        .tbl_we     (tbl_we),
        .tbl_clear  (tbl_clear),
        .tbl_idx    (tbl_idx),
        .tbl_tag    (tbl_tag),
        .tbl_taken  (tbl_taken),
        .tbl_target (tbl_target),
        .init_done  (init_done),
        .drop_cnt   (drop_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        clear;
        logic [2:0]  idx;
        logic [26:0] tag;
        logic        taken;
        logic [31:0] target;
    } wr_t;

    wr_t sb_q[$];
    int  total = 0;
    int  bad = 0;
    int  exp_drop = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic wr_t upd_wr(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        wr_t w;
        w.clear  = 1'b0;
        w.idx    = pc[4:2];
        w.tag    = pc[31:5];
        w.taken  = tk;
        w.target = tg;
        return w;
    endfunction

    function automatic wr_t clr_wr(input int i);
        wr_t w;
        w        = '0;
        w.clear  = 1'b1;
        w.idx    = i[2:0];
        return w;
    endfunction

    // Anything still queued is discarded; a full clear sweep is expected next.
    task automatic exp_sweep();
        sb_q.delete();
        for (int i = 0; i < 8; i++) sb_q.push_back(clr_wr(i));
    endtask

    always @(negedge CLK) begin
        wr_t act;
        wr_t exp;
        if (RESET && tbl_we) begin
            act = {tbl_clear, tbl_idx, tbl_tag, tbl_taken, tbl_target};
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got %0h expected no write at %0t", act, $time);
            end else begin
                exp = sb_q.pop_front();
                chk("write", act, exp);
            end
        end
    end

    // One clock cycle of stimulus; returns 1ns after the rising edge that ends the cycle.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tg, input logic st, input logic fl,
                       input logic exp_rdy);
        upd_valid  = v;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tg;
        STALL      = st;
        flush_req  = fl;
        #1;
        chk("upd_ready", upd_ready, exp_rdy);
        if (v && exp_rdy) sb_q.push_back(upd_wr(pc, tk, tg));
        if (v && !exp_rdy && exp_drop < DROP_MAX) exp_drop++;
        @(posedge CLK);
        if (fl) exp_sweep();
        #1;
        upd_valid = 1'b0;
        flush_req = 1'b0;
    endtask

    task automatic idle(input logic st, input logic exp_rdy);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, st, 1'b0, exp_rdy);
    endtask

    task automatic sweep_check(input string n);
        for (int k = 0; k < 8; k++) begin
            idle(k[0], 1'b0);
            chk({n, "_we"}, tbl_we, 1'b1);
            chk({n, "_idx"}, tbl_idx, k[2:0]);
            chk({n, "_init_done"}, init_done, 1'b0);
        end
        idle(1'b0, 1'b1);
        chk({n, "_end_we"}, tbl_we, 1'b0);
        chk({n, "_end_init_done"}, init_done, 1'b1);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_we", tbl_we, 1'b0);
        chk("rst_clear", tbl_clear, 1'b0);
        chk("rst_idx", tbl_idx, 3'd0);
        chk("rst_target", tbl_target, 32'h0);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_drop", drop_cnt, 4'd0);
        chk("rst_ready", upd_ready, 1'b0);

        exp_sweep();
        RESET = 1'b1;
        sweep_check("boot");

        // Single update: visible two cycles after acceptance.
        cyc(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 1'b0, 1'b1);
        chk("lat_n1_we", tbl_we, 1'b0);
        idle(1'b0, 1'b1);
        chk("lat_n2_we", tbl_we, 1'b1);
        chk("lat_n2_idx", tbl_idx, 3'd4);
        chk("lat_n2_tag", tbl_tag, 27'h002_0000);
        chk("lat_n2_taken", tbl_taken, 1'b1);
        chk("lat_n2_target", tbl_target, 32'h0040_0100);
        idle(1'b0, 1'b1);
        chk("lat_after_we", tbl_we, 1'b0);

        // Fill under STALL, overflow drops one, then drain in order.
        cyc(1'b1, 32'h1000_0004, 1'b1, 32'hA000_0000, 1'b1, 1'b0, 1'b1);
        chk("stall1_we", tbl_we, 1'b0);
        cyc(1'b1, 32'h1000_0024, 1'b0, 32'hA000_0010, 1'b1, 1'b0, 1'b1);
        chk("stall2_we", tbl_we, 1'b0);
        cyc(1'b1, 32'h2000_0008, 1'b1, 32'hB000_0020, 1'b1, 1'b0, 1'b1);
        chk("stall3_we", tbl_we, 1'b0);
        cyc(1'b1, 32'h3000_001C, 1'b0, 32'hC000_0030, 1'b1, 1'b0, 1'b1);
        chk("stall4_we", tbl_we, 1'b0);
        cyc(1'b1, 32'h4000_0000, 1'b1, 32'hD000_0040, 1'b1, 1'b0, 1'b0);
        chk("full_drop", drop_cnt, exp_drop);
        chk("full_we", tbl_we, 1'b0);
        idle(1'b0, 1'b0);
        chk("drain1_we", tbl_we, 1'b1);
        for (int i = 2; i <= 4; i++) begin
            idle(1'b0, 1'b1);
            chk("drain_we", tbl_we, 1'b1);
        end
        idle(1'b0, 1'b1);
        chk("drain_done_we", tbl_we, 1'b0);

        // Push and pop together at count=2 leaves count at 2.
        cyc(1'b1, 32'h0000_1000, 1'b1, 32'h0000_2000, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 32'h0000_1004, 1'b0, 32'h0000_2004, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 32'h0000_1008, 1'b1, 32'h0000_2008, 1'b0, 1'b0, 1'b1);
        chk("pushpop_we", tbl_we, 1'b1);
        chk("pushpop_drop", drop_cnt, exp_drop);
        cyc(1'b1, 32'h0000_100C, 1'b0, 32'h0000_200C, 1'b1, 1'b0, 1'b1);
        chk("pushpop_stall_we", tbl_we, 1'b0);
        cyc(1'b1, 32'h0000_1010, 1'b1, 32'h0000_2010, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 32'h0000_1014, 1'b0, 32'h0000_2014, 1'b1, 1'b0, 1'b0);
        chk("pushpop_full_drop", drop_cnt, exp_drop);
        idle(1'b0, 1'b0);
        chk("pp_drain1_we", tbl_we, 1'b1);
        for (int i = 2; i <= 4; i++) begin
            idle(1'b0, 1'b1);
            chk("pp_drain_we", tbl_we, 1'b1);
        end
        idle(1'b0, 1'b1);
        chk("pp_drain_done_we", tbl_we, 1'b0);

        // Flush with three queued entries: none written, full sweep, drops kept.
        cyc(1'b1, 32'h5000_0000, 1'b1, 32'hE000_0000, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 32'h5000_0004, 1'b1, 32'hE000_0004, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 32'h5000_0008, 1'b1, 32'hE000_0008, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("flush_we", tbl_we, 1'b0);
        chk("flush_init_done", init_done, 1'b0);
        sweep_check("flush");
        chk("flush_drop", drop_cnt, exp_drop);

        // Flush partway through a sweep restarts it at index 0.
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            idle(1'b0, 1'b0);
            chk("part_idx", tbl_idx, k[2:0]);
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("restart_we", tbl_we, 1'b0);
        sweep_check("restart");

        // Drop counter saturates.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'h6000_0000 + 32'(i * 4), 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        end
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 32'h7000_0000, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
        end
        chk("drop_sat", drop_cnt, 4'hF);

        // Async reset while index 5 is on the write port.
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            idle(1'b1, 1'b0);
        end
        chk("pre_rst_idx", tbl_idx, 3'd5);
        RESET = 1'b0;
        #1;
        chk("midrst_we", tbl_we, 1'b0);
        chk("midrst_clear", tbl_clear, 1'b0);
        chk("midrst_idx", tbl_idx, 3'd0);
        chk("midrst_drop", drop_cnt, 4'd0);
        chk("midrst_init_done", init_done, 1'b0);
        exp_drop = 0;
        exp_sweep();
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        sweep_check("after_rst");

        repeat (3) idle(1'b0, 1'b1);
        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
